// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port.
// Merges in-order pipeline writebacks with queued mult/div completions.
//
// Ports:
//   clock, ctrl_reset_n          clock, async active-low reset
//   pipe_we/rd/data/exc/exc_code pipeline W-stage write (never refused)
//   pipe_stall                   ask upstream for an empty W slot
//   md_valid/ready/rd/data/...   mult/div result handshake into the FIFO
//   md_pending_mask              one bit per register with a queued write
//   wb_waw_err                   sticky: a queued write was overtaken
//   ctrl_writeEnable/writeReg,
//   data_writeReg                registered regfile write controls
module regfile_wb_arbiter #(
    parameter int         MD_DEPTH   = 4,
    parameter int         STARVE_LIM = 8,
    parameter logic [4:0] STATUS_REG = 5'd30
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        pipe_exc,
    input  logic [31:0] pipe_exc_code,
    output logic        pipe_stall,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_exc,
    input  logic [31:0] md_exc_code,
    output logic [31:0] md_pending_mask,
    output logic        wb_waw_err,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    localparam int PW = $clog2(MD_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [4:0]          q_rd   [MD_DEPTH];
    logic [31:0]         q_data [MD_DEPTH];
    logic [MD_DEPTH-1:0] q_vld, vld_n, kill_vec;
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [SW-1:0]       starve, starve_n;

    logic [4:0]  pipe_dest, md_dest, wr_reg_n;
    logic [31:0] pipe_wdata, md_wdata, wr_data_n;
    logic        pipe_live, md_acc, md_kill, push;
    logic        not_empty, head_vld, pop, pop_md, wr_en_n;

    assign pipe_dest  = pipe_exc ? STATUS_REG : pipe_rd;
    assign pipe_wdata = pipe_exc ? pipe_exc_code : pipe_data;
    assign md_dest    = md_exc ? STATUS_REG : md_rd;
    assign md_wdata   = md_exc ? md_exc_code : md_data;

    assign pipe_live = pipe_we && (pipe_dest != 5'd0);
    assign md_ready  = count < CW'(MD_DEPTH);
    assign md_acc    = md_valid && md_ready;
    // An incoming result already overtaken by this cycle's pipeline
    // write is dropped rather than queued as a dead entry.
    assign md_kill   = md_acc && pipe_live && (md_dest == pipe_dest);
    assign push      = md_acc && (md_dest != 5'd0) && !md_kill;

    assign not_empty = count != '0;
    assign head_vld  = not_empty && q_vld[rd_ptr];
    assign pop_md    = head_vld && !pipe_live;
    // Dead heads need no write slot, so they drain even under a live pipe.
    assign pop       = pop_md || (not_empty && !q_vld[rd_ptr]);

    always_comb begin
        kill_vec        = '0;
        md_pending_mask = '0;
        for (int i = 0; i < MD_DEPTH; i++) begin
            if (q_vld[i]) begin
                md_pending_mask[q_rd[i]] = 1'b1;
                if (pipe_live && (q_rd[i] == pipe_dest))
                    kill_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        vld_n = q_vld & ~kill_vec;
        if (pop)
            vld_n[rd_ptr] = 1'b0;
        if (push)
            vld_n[wr_ptr] = 1'b1;
    end

    always_comb begin
        starve_n = starve;
        if (!not_empty || pop)
            starve_n = '0;
        else if (starve != SW'(STARVE_LIM))
            starve_n = starve + SW'(1);
    end

    always_comb begin
        wr_en_n   = 1'b0;
        wr_reg_n  = ctrl_writeReg;
        wr_data_n = data_writeReg;
        unique case (1'b1)
            pipe_live: begin
                wr_en_n   = 1'b1;
                wr_reg_n  = pipe_dest;
                wr_data_n = pipe_wdata;
            end
            pop_md: begin
                wr_en_n   = 1'b1;
                wr_reg_n  = q_rd[rd_ptr];
                wr_data_n = q_data[rd_ptr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_rd[wr_ptr]   <= md_dest;
            q_data[wr_ptr] <= md_wdata;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            q_vld            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            starve           <= '0;
            pipe_stall       <= 1'b0;
            wb_waw_err       <= 1'b0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
        end else begin
            q_vld            <= vld_n;
            rd_ptr           <= rd_ptr + PW'(pop);
            wr_ptr           <= wr_ptr + PW'(push);
            count            <= count + CW'(push) - CW'(pop);
            starve           <= starve_n;
            pipe_stall       <= starve_n == SW'(STARVE_LIM);
            wb_waw_err       <= wb_waw_err | md_kill | (|kill_vec);
            ctrl_writeEnable <= wr_en_n;
            ctrl_writeReg    <= wr_reg_n;
            data_writeReg    <= wr_data_n;
        end
    end

endmodule
